// File: rtl/ntt_stage_sequencer_pkg.sv
// Shared types and constants for the NTT stage sequencer.
//   ntt_seq_state_e : sequencer FSM states
//   NTT_PIPE_LAT    : read-issue to write-back latency (sync RAM read + butterfly register)
package ntt_stage_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ntt_seq_state_e;

  localparam int unsigned NTT_PIPE_LAT = 2;

endpackage

// File: rtl/ntt_stage_sequencer_if.sv
// Control/RAM-side bundle of the NTT stage sequencer.
//   start, intt_req            : transform request and its mode (host -> sequencer)
//   busy, done, intt_mode      : status and the latched mode (sequencer -> host/butterfly)
//   rd_en, rd_addr_a/b, tw_addr: read issue to coefficient RAM and twiddle ROM
//   wr_en, wr_addr_a/b         : write-back to coefficient RAM
// modport master: host/environment side; modport slave: the sequencer.
interface ntt_stage_sequencer_if #(
  parameter int unsigned LOGN = 8
);
  logic            start;
  logic            intt_req;
  logic            busy;
  logic            done;
  logic            intt_mode;
  logic            rd_en;
  logic [LOGN-1:0] rd_addr_a;
  logic [LOGN-1:0] rd_addr_b;
  logic [LOGN-2:0] tw_addr;
  logic            wr_en;
  logic [LOGN-1:0] wr_addr_a;
  logic [LOGN-1:0] wr_addr_b;

  modport master (
    output start, intt_req,
    input  busy, done, intt_mode, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
    input  start, intt_req,
    output busy, done, intt_mode, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/ntt_stage_sequencer_addr_gen.sv
// Combinational Cooley-Tukey DIT butterfly addressing.
//   s       : stage index
//   j       : butterfly index within the stage (0..N/2-1)
//   addr_a  : upper-leg address  (grp << (s+1)) | off
//   addr_b  : lower-leg address  addr_a + (1 << s)
//   tw_addr : twiddle index      off << (LOGN-1-s)
module ntt_addr_gen #(
  parameter int unsigned LOGN = 8
) (
  input  logic [LOGN-1:0] s,
  input  logic [LOGN-2:0] j,
  output logic [LOGN-1:0] addr_a,
  output logic [LOGN-1:0] addr_b,
  output logic [LOGN-2:0] tw_addr
);
  logic [LOGN-1:0] j_ext;
  logic [LOGN-1:0] len;
  logic [LOGN-1:0] off;
  logic [LOGN-1:0] grp;
  logic [LOGN-1:0] tw_shift;

  always_comb begin
    j_ext    = {1'b0, j};
    len      = LOGN'(1) << s;
    off      = j_ext & (len - LOGN'(1));
    grp      = j_ext >> s;
    addr_a   = (grp << (s + LOGN'(1))) | off;
    addr_b   = addr_a + len;
    tw_shift = LOGN'(LOGN - 1) - s;
    // off < N/2 because j < N/2, so its top bit is always zero
    tw_addr  = off[LOGN-2:0] << tw_shift;
  end
endmodule

// File: rtl/ntt_stage_sequencer.sv
// Sequencer for one in-place radix-2 NTT/iNTT over an N-entry dual-port RAM
// using a single pipelined butterfly. Walks LOGN stages of N/2 butterflies,
// one read issue per cycle, and drains PIPE_LAT cycles between stages so no
// read overtakes a pending write-back.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of ntt_stage_sequencer_if (start/mode in,
//                status, read issue and write-back out)
module ntt_stage_sequencer
  import ntt_stage_sequencer_pkg::*;
#(
  parameter int unsigned N        = 256,
  parameter int unsigned LOGN     = $clog2(N),
  parameter int unsigned PIPE_LAT = NTT_PIPE_LAT
) (
  input logic                  clk,
  input logic                  reset,
  ntt_stage_sequencer_if.slave bus
);
  localparam int unsigned     DW         = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DW-1:0]   DRAIN_LAST = DW'(PIPE_LAT - 1);
  localparam logic [LOGN-2:0] J_LAST     = (LOGN-1)'(N / 2 - 1);
  localparam logic [LOGN-1:0] S_LAST     = LOGN'(LOGN - 1);

  ntt_seq_state_e  state, state_n;
  logic [LOGN-1:0] s, s_n;
  logic [LOGN-2:0] j, j_n;
  logic [DW-1:0]   dcnt, dcnt_n;
  logic            issue;
  logic [LOGN-1:0] nxt_a, nxt_b;
  logic [LOGN-2:0] nxt_tw;

  logic            pipe_v [PIPE_LAT];
  logic [LOGN-1:0] pipe_a [PIPE_LAT];
  logic [LOGN-1:0] pipe_b [PIPE_LAT];

  always_comb begin
    state_n = state;
    s_n     = s;
    j_n     = j;
    dcnt_n  = dcnt;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_n = ST_RUN;
          s_n     = '0;
          j_n     = '0;
        end
      end
      ST_RUN: begin
        if (j == J_LAST) begin
          state_n = ST_DRAIN;
          dcnt_n  = '0;
        end else begin
          j_n = j + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (dcnt == DRAIN_LAST) begin
          if (s == S_LAST) begin
            state_n = ST_DONE;
          end else begin
            state_n = ST_RUN;
            s_n     = s + 1'b1;
            j_n     = '0;
          end
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Read outputs are registered from the next-state view so the first read
  // lands in the cycle right after the accepting edge.
  assign issue = (state_n == ST_RUN);

  ntt_addr_gen #(.LOGN(LOGN)) u_addr_gen (
    .s       (s_n),
    .j       (j_n),
    .addr_a  (nxt_a),
    .addr_b  (nxt_b),
    .tw_addr (nxt_tw)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      s             <= '0;
      j             <= '0;
      dcnt          <= '0;
      bus.intt_mode <= 1'b0;
      bus.rd_en     <= 1'b0;
      bus.rd_addr_a <= '0;
      bus.rd_addr_b <= '0;
      bus.tw_addr   <= '0;
    end else begin
      state <= state_n;
      s     <= s_n;
      j     <= j_n;
      dcnt  <= dcnt_n;
      if (state == ST_IDLE && bus.start) begin
        bus.intt_mode <= bus.intt_req;
      end
      bus.rd_en     <= issue;
      bus.rd_addr_a <= issue ? nxt_a : '0;
      bus.rd_addr_b <= issue ? nxt_b : '0;
      bus.tw_addr   <= issue ? nxt_tw : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < PIPE_LAT; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_a[i] <= '0;
        pipe_b[i] <= '0;
      end
    end else begin
      pipe_v[0] <= bus.rd_en;
      pipe_a[0] <= bus.rd_addr_a;
      pipe_b[0] <= bus.rd_addr_b;
      for (int unsigned i = 1; i < PIPE_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
        pipe_b[i] <= pipe_b[i-1];
      end
    end
  end

  assign bus.wr_en     = pipe_v[PIPE_LAT-1];
  assign bus.wr_addr_a = pipe_a[PIPE_LAT-1];
  assign bus.wr_addr_b = pipe_b[PIPE_LAT-1];
  assign bus.busy      = (state == ST_RUN) || (state == ST_DRAIN);
  assign bus.done      = (state == ST_DONE);
endmodule
